// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: 2-FF synchroniser, prescaled per-bit debounce,
// edge pulses, sticky edge flags and a masked interrupt request.
module gpio_in_filter #(
   parameter int unsigned    DW       = 16,
   parameter int unsigned    DIV_W    = 16,
   parameter int unsigned    STABLE_N = 4,
   parameter logic [DW-1:0]  RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DW-1:0]    pin_in,
   input  logic [DIV_W-1:0] div,
   input  logic [DW-1:0]    irq_en,
   input  logic [DW-1:0]    flag_clr,
   output logic [DW-1:0]    filt_out,
   output logic [DW-1:0]    rise,
   output logic [DW-1:0]    fall,
   output logic [DW-1:0]    edge_flag,
   output logic             irq
);

   localparam logic [3:0] CntMax = 4'(STABLE_N - 1);

   logic [DW-1:0]    s1_q, s2_q;
   logic [DIV_W-1:0] pre_q, pre_d;
   logic             tick;
   logic [3:0]       cnt_q [DW];
   logic [3:0]       cnt_d [DW];
   logic [DW-1:0]    filt_q, filt_d, filt_dly_q;
   logic [DW-1:0]    rise_q, rise_d, fall_q, fall_d;
   logic [DW-1:0]    flag_q, flag_d;
   logic             irq_q, irq_d;

   // >= rather than == so lowering div below the running count ticks at once
   always_comb begin
      tick  = (pre_q >= div);
      pre_d = tick ? '0 : pre_q + DIV_W'(1);
   end

   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < DW; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (s2_q[i] == filt_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
               filt_d[i] = s2_q[i];
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   // Flags use the pulse terms being registered this edge so they appear together
   always_comb begin
      rise_d = filt_q & ~filt_dly_q;
      fall_d = ~filt_q & filt_dly_q;
      flag_d = (flag_q & ~flag_clr) | rise_d | fall_d;
      irq_d  = |(flag_q & irq_en);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= '0;
         s2_q       <= '0;
         pre_q      <= '0;
         filt_q     <= RST_VAL;
         filt_dly_q <= RST_VAL;
         rise_q     <= '0;
         fall_q     <= '0;
         flag_q     <= '0;
         irq_q      <= 1'b0;
         for (int i = 0; i < DW; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q       <= pin_in;
         s2_q       <= s1_q;
         pre_q      <= pre_d;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         flag_q     <= flag_d;
         irq_q      <= irq_d;
         for (int i = 0; i < DW; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign filt_out  = filt_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign edge_flag = flag_q;
   assign irq       = irq_q;

endmodule
